pc_redirect_ctrl: RTL
=====================

Name: pc_redirect_ctrl

Overview:
- Owns the fetch PC register and sequences every PC update.
- Arbitrates redirect requests from EXE (branch/JR, immediate jump) and MEM (exception, ERET, refetch).
- Honours the MIPS delay slot: a branch target is applied only after the delay slot has been accepted by fetch.
- Handshakes with the IF stage and drives the select code consumed by the next-PC mux, using the team's PCSel encoding.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded at reset.
- PC_STEP, 32'd4, sequential increment.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- fetch_ready  in  1  IF accepts current pc this cycle
- except_req  in  1  exception from MEM
- except_target  in  32  exception vector
- eret_req  in  1  ERET from MEM
- epc  in  32  EPC value
- refetch_req  in  1  refetch from MEM
- mem_pc  in  32  refetch address
- branch_req  in  1  taken branch or JR resolved in EXE
- branch_is_jr  in  1  branch is JR/JALR
- branch_target  in  32  branch/JR target
- branch_ds_fetched  in  1  delay slot of this branch already accepted by IF
- jump_req  in  1  immediate jump (J/JAL)
- jump_target  in  32  jump target
- pc  out  32  current fetch PC
- fetch_req  out  1  IF may issue pc
- pc_sel  out  3  source of this cycle's PC update: 000 PC4, 001 ImmeJump, 010 EPC, 011 Except, 100 Branch, 101 JR, 110 MEMPC
- redirect  out  1  pc loaded with a non-sequential value this cycle
- flush_if  out  1  kill in-flight IF request/instruction
- wait_ds  out  1  state==WAIT_DS

Behaviour:
- Clock and reset: single clock clk; reset resetn is synchronous and active-low.
- Reset values: pc=RESET_PC; state=FLUSH; stored target=0; fetch_req=0; pc_sel=000; redirect=0; flush_if=0; wait_ds=0. Reset asserted mid-operation discards any pending target.
- States: RUN, WAIT_DS, FLUSH. fetch_req = (state != FLUSH).
- Priority (combinational, one winner per cycle): except > eret > refetch > branch > jump > sequential.
- pc_sel, redirect and flush_if are combinational from the current inputs and state. They describe the update written to pc at the next edge.

MEM-class requests (except/eret/refetch):
- Honoured in every state, regardless of fetch_ready.
- pc <= except_target / epc / mem_pc; pc_sel = 011 / 010 / 110.
- redirect=1, flush_if=1.
- Any stored branch target is discarded; next state = FLUSH.

FLUSH:
- One bubble cycle; branch_req and jump_req are ignored (wrong-path).
- Without a MEM-class request: pc holds, pc_sel=000, next state = RUN.

RUN, branch or jump winner (jump counts as branch_ds_fetched semantics identical):
- If branch_ds_fetched=1: pc <= target immediately, irrespective of fetch_ready. pc_sel=101 if JR else 100 (001 for jump); redirect=1; flush_if=1; stay RUN.
- Else if fetch_ready=1 (delay slot accepted this cycle): pc <= target; redirect=1; flush_if=0; stay RUN.
- Else: store target and sel; pc holds (it is the delay slot address); next state = WAIT_DS.

RUN, no request:
- fetch_ready=1 -> pc <= pc+PC_STEP (modulo 2^32; 32'hFFFF_FFFC wraps to 0), pc_sel=000.
- fetch_ready=0 -> pc holds.

WAIT_DS:
- New branch/jump requests are ignored (no branch in delay slot).
- On fetch_ready=1: pc <= stored target; pc_sel = stored sel; redirect=1; next state = RUN.
- Otherwise pc holds.

Simultaneous events:
- branch_req and jump_req together: branch wins; jump dropped.
- MEM-class request together with fetch_ready in WAIT_DS: MEM-class wins; stored target lost.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- When defined: extra output fetch_adel (1 bit, reset 0) = fetch_req & (pc[1:0] != 2'b00). pc is still presented, and the exception is raised downstream. Branch/jump targets with target[1:0] != 0 are loaded unchanged.
- When undefined: port absent, no check logic.

Test Plan:
- Reset release: resetn=0 for 2 cycles, then 1; fetch_ready=1 -> pc=BFC00000 with fetch_req=0 for 1 cycle, then pc=BFC00004, BFC00008 on consecutive cycles.
- Branch, delay slot pending: pc=80000010, branch_req=1, branch_ds_fetched=0, target=80000100, fetch_ready=0 for 3 cycles -> wait_ds=1, pc holds 80000010. Then fetch_ready=1 -> pc=80000100, pc_sel=100, redirect=1, flush_if=0.
- JR, delay slot done: branch_ds_fetched=1, branch_is_jr=1, target=80001234, fetch_ready=0 -> next pc=80001234, pc_sel=101, flush_if=1.
- Exception in WAIT_DS: stored target 80000100 with except_req=1, except_target=BFC00380 -> pc=BFC00380, pc_sel=011. Next cycle fetch_req=0 and branch_req ignored. Then RUN; 80000100 never loaded.
- Priority and FLUSH: except, eret and branch all asserted together -> pc=except_target. Eret alone (epc=80002000) -> pc_sel=010, flush bubble, then sequential 80002004.
- Wrap and misalign: pc=FFFFFFFC, fetch_ready=1 -> pc=00000000. With PC_MISALIGN_CHECK_EN, jump_target=80000002 -> fetch_adel=1 while pc=80000002.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Purpose: owns the fetch PC, arbitrating MEM/EXE redirects and honouring the MIPS delay slot.
// Latency: pc_sel/redirect/flush_if are combinational; pc updates at the next clk edge.
// Backpressure: fetch_ready stalls sequential/delay-slot progress; MEM-class redirects ignore it.
// Optional: define PC_MISALIGN_CHECK_EN to add the fetch_adel output.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_ready,
    input  logic        except_req,
    input  logic [31:0] except_target,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        refetch_req,
    input  logic [31:0] mem_pc,
    input  logic        branch_req,
    input  logic        branch_is_jr,
    input  logic [31:0] branch_target,
    input  logic        branch_ds_fetched,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic        fetch_req,
    output logic [2:0]  pc_sel,
    output logic        redirect,
    output logic        flush_if,
`ifdef PC_MISALIGN_CHECK_EN
    output logic        fetch_adel,
`endif
    output logic        wait_ds
);

    localparam logic [2:0] SEL_PC4    = 3'b000;
    localparam logic [2:0] SEL_IMMJ   = 3'b001;
    localparam logic [2:0] SEL_EPC    = 3'b010;
    localparam logic [2:0] SEL_EXCEPT = 3'b011;
    localparam logic [2:0] SEL_BRANCH = 3'b100;
    localparam logic [2:0] SEL_JR     = 3'b101;
    localparam logic [2:0] SEL_MEMPC  = 3'b110;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_DS = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [2:0]  tsel_q, tsel_d;

    logic [2:0]  sel_c;
    logic        redirect_c;
    logic        flush_c;
    logic [31:0] exe_tgt;
    logic [2:0]  exe_sel;

    // EXE winner: branch beats jump when both are raised in the same cycle.
    always_comb begin
        exe_tgt = jump_target;
        exe_sel = SEL_IMMJ;
        if (branch_req) begin
            exe_tgt = branch_target;
            exe_sel = branch_is_jr ? SEL_JR : SEL_BRANCH;
        end
    end

    // Next-state, next-pc and redirect decode; MEM-class requests override everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        tsel_d     = tsel_q;
        sel_c      = SEL_PC4;
        redirect_c = 1'b0;
        flush_c    = 1'b0;
        if (except_req || eret_req || refetch_req) begin
            redirect_c = 1'b1;
            flush_c    = 1'b1;
            state_d    = FLUSH;
            tgt_d      = 32'd0;
            tsel_d     = SEL_PC4;
            if (except_req) begin
                pc_d  = except_target;
                sel_c = SEL_EXCEPT;
            end else if (eret_req) begin
                pc_d  = epc;
                sel_c = SEL_EPC;
            end else begin
                pc_d  = mem_pc;
                sel_c = SEL_MEMPC;
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    // Wrong-path bubble: EXE requests are dropped here.
                    state_d = RUN;
                end
                WAIT_DS: begin
                    if (fetch_ready) begin
                        pc_d       = tgt_q;
                        sel_c      = tsel_q;
                        redirect_c = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: begin
                    if (branch_req || jump_req) begin
                        if (branch_ds_fetched) begin
                            pc_d       = exe_tgt;
                            sel_c      = exe_sel;
                            redirect_c = 1'b1;
                            flush_c    = 1'b1;
                        end else if (fetch_ready) begin
                            pc_d       = exe_tgt;
                            sel_c      = exe_sel;
                            redirect_c = 1'b1;
                        end else begin
                            // pc is the delay-slot address; park the target until IF takes it.
                            tgt_d   = exe_tgt;
                            tsel_d  = exe_sel;
                            state_d = WAIT_DS;
                        end
                    end else if (fetch_ready) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            endcase
        end
    end

    // PC, state and parked-target registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= FLUSH;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'd0;
            tsel_q  <= SEL_PC4;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            tsel_q  <= tsel_d;
        end
    end

    assign pc        = pc_q;
    assign fetch_req = (state_q != FLUSH);
    assign wait_ds   = (state_q == WAIT_DS);
    assign pc_sel    = resetn ? sel_c : SEL_PC4;
    assign redirect  = resetn & redirect_c;
    assign flush_if  = resetn & flush_c;

`ifdef PC_MISALIGN_CHECK_EN
    assign fetch_adel = fetch_req & (pc_q[1:0] != 2'b00);
`endif

endmodule
